capture_fifo: RTL

//  Captures the 8-bit result bus (cell outputs or ring-oscillator count) into a

---
 rtl/capture_fifo_if.sv | 23 ++
 rtl/capture_fifo.sv | 61 ++++++
 2 files changed

// File: rtl/capture_fifo_if.sv
// capture_fifo_if: capture/readback bus between the result source, the reader and capture_fifo.
interface capture_fifo_if #(parameter int WIDTH = 8, parameter int DEPTH = 8);
  logic [WIDTH-1:0]         sample_in;
  logic                     sample_en;
  logic                     every_cycle;
  logic                     clear;
  logic                     rd_en;
  logic [WIDTH-1:0]         rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     overflow;
  logic [WIDTH-1:0]         min_val;
  logic [WIDTH-1:0]         max_val;
  modport master (
    output sample_in, sample_en, every_cycle, clear, rd_en,
    input  rd_data, rd_valid, count, full, overflow, min_val, max_val
  );
  modport slave (
    input  sample_in, sample_en, every_cycle, clear, rd_en,
    output rd_data, rd_valid, count, full, overflow, min_val, max_val
  );
endinterface

// File: rtl/capture_fifo.sv
// capture_fifo: buffers result-bus samples (every cycle or on change) with sticky overflow and running min/max.
module capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  capture_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] last, mn, mx;
  logic             first_pend, ovf, empty, pop, cap, wr;
  assign empty        = cnt == '0;
  assign bus.full     = cnt == CW'(DEPTH);
  assign bus.rd_valid = !empty;
  assign bus.count    = cnt;
  assign bus.rd_data  = mem[rp];
  assign bus.overflow = ovf;
  assign bus.min_val  = mn;
  assign bus.max_val  = mx;
  assign pop = bus.rd_en & !empty;
  assign cap = bus.sample_en & (bus.every_cycle | first_pend | (bus.sample_in != last));
  // a pop in the same cycle frees the slot a full buffer needs
  assign wr  = cap & (!bus.full | pop);
  always_ff @(posedge clk)
    if (wr && !bus.clear) mem[wp] <= bus.sample_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      mn         <= '1;
      mx         <= '0;
      last       <= '0;
      first_pend <= 1'b1;
    end else begin
      if (bus.sample_en) last <= bus.sample_in;
      if (bus.clear) begin
        wp         <= '0;
        rp         <= '0;
        cnt        <= '0;
        ovf        <= 1'b0;
        mn         <= '1;
        mx         <= '0;
        first_pend <= 1'b1;
      end else begin
        first_pend <= !bus.sample_en;
        if (pop) rp <= rp + 1'b1;
        if (wr) wp <= wp + 1'b1;
        cnt <= cnt + CW'(wr) - CW'(pop);
        if (cap && !wr) ovf <= 1'b1;
        if (wr && bus.sample_in < mn) mn <= bus.sample_in;
        if (wr && bus.sample_in > mx) mx <= bus.sample_in;
      end
    end
endmodule
